// File: rtl/dmi_resp_stage.sv
// dmi_resp_stage: buffer stage on the DMI response path (DM -> DTM).
// A small FIFO with registered valid/ready. Ready towards the producer depends
// only on the stage's own occupancy, so no combinational path runs from
// dmi_resp_ready_i to dmi_resp_ready_o.
//
// Ports:
//   clk_i            clock, all logic on posedge
//   rst_i            synchronous active-high reset (clears pointers, count, storage)
//   dmi_resp_i       response from DM, {data[31:0], resp[1:0]}
//   dmi_resp_valid_i producer valid
//   dmi_resp_ready_o stage can accept (!full)
//   dmi_resp_o       head-of-queue response, 0 when empty
//   dmi_resp_valid_o head valid (!empty)
//   dmi_resp_ready_i consumer ready
//   flush_i          synchronous discard of all buffered entries
//   count_o          number of occupied entries, 0..DEPTH
module dmi_resp_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [33:0]     dmi_resp_i,
    input  logic            dmi_resp_valid_i,
    output logic            dmi_resp_ready_o,
    output logic [33:0]     dmi_resp_o,
    output logic            dmi_resp_valid_o,
    input  logic            dmi_resp_ready_i,
    input  logic            flush_i,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [33:0]     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [PtrW-1:0] ptr_diff;

    assign full     = (count == CntW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = dmi_resp_valid_i && !full;
    assign pop      = !empty && dmi_resp_ready_i;
    assign ptr_diff = wr_ptr - rd_ptr;

    // Pointers are log2(DEPTH) bits wide, so DEPTH being a power of two
    // makes the natural binary overflow the modulo-DEPTH wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Storage is left as-is; the empty view masks stale contents.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dmi_resp_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        dmi_resp_o       = empty ? '0 : mem[rd_ptr];
        dmi_resp_valid_o = !empty;
        dmi_resp_ready_o = !full;
        count_o          = count;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && empty));
    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CntW'(DEPTH));
    // When full the pointers coincide, so the difference alone reads as 0.
    a_count_ptrs: assert property (@(posedge clk_i) disable iff (rst_i)
        full ? (ptr_diff == '0) : (CntW'(ptr_diff) == count));

endmodule

// File: tb/tb_dmi_resp_stage.sv
// tb_dmi_resp_stage: bench for dmi_resp_stage with a DEPTH=2 and a DEPTH=4
// instance. Expected outputs come from a capacity-bounded queue per instance.
module tb_dmi_resp_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // DEPTH=2 instance
    logic        a_rst, a_valid_i, a_ready_i, a_flush;
    logic [33:0] a_data_i;
    logic        a_ready_o, a_valid_o;
    logic [33:0] a_data_o;
    logic [1:0]  a_count;

    // DEPTH=4 instance
    logic        b_rst, b_valid_i, b_ready_i, b_flush;
    logic [33:0] b_data_i;
    logic        b_ready_o, b_valid_o;
    logic [33:0] b_data_o;
    logic [2:0]  b_count;

    dmi_resp_stage #(.DEPTH(2)) u_dut2 (
        .clk_i            (clk),
        .rst_i            (a_rst),
        .dmi_resp_i       (a_data_i),
        .dmi_resp_valid_i (a_valid_i),
        .dmi_resp_ready_o (a_ready_o),
        .dmi_resp_o       (a_data_o),
        .dmi_resp_valid_o (a_valid_o),
        .dmi_resp_ready_i (a_ready_i),
        .flush_i          (a_flush),
        .count_o          (a_count)
    );

    dmi_resp_stage #(.DEPTH(4)) u_dut4 (
        .clk_i            (clk),
        .rst_i            (b_rst),
        .dmi_resp_i       (b_data_i),
        .dmi_resp_valid_i (b_valid_i),
        .dmi_resp_ready_o (b_ready_o),
        .dmi_resp_o       (b_data_o),
        .dmi_resp_valid_o (b_valid_o),
        .dmi_resp_ready_i (b_ready_i),
        .flush_i          (b_flush),
        .count_o          (b_count)
    );

    // Reference model: an ordered list of held responses, bounded by DEPTH.
    logic [33:0] qa[$];
    logic [33:0] qb[$];
    bit          a_accepted;   // last step2 pushed the offered beat
    bit          b_accepted;
    int unsigned b_popped;
    logic [33:0] b_pop_log[$];

    function automatic logic [38:0] exp2();
        logic [33:0] head;
        head = (qa.size() > 0) ? qa[0] : 34'h0;
        return {1'b0, qa.size() > 0, qa.size() < 2, 2'(qa.size()), head};
    endfunction

    function automatic logic [38:0] obs2();
        return {1'b0, a_valid_o, a_ready_o, a_count, a_data_o};
    endfunction

    function automatic logic [38:0] exp4();
        logic [33:0] head;
        head = (qb.size() > 0) ? qb[0] : 34'h0;
        return {qb.size() > 0, qb.size() < 4, 3'(qb.size()), head};
    endfunction

    function automatic logic [38:0] obs4();
        return {b_valid_o, b_ready_o, b_count, b_data_o};
    endfunction

    function automatic logic [33:0] beat(input logic [31:0] d, input logic [1:0] r);
        return {d, r};
    endfunction

    // One clock on the DEPTH=2 instance; the model follows the queue rules.
    task automatic step2(input logic v, input logic [33:0] d, input logic rdy,
                         input logic fl, input logic rs);
        bit do_push, do_pop;
        a_valid_i = v; a_data_i = d; a_ready_i = rdy; a_flush = fl; a_rst = rs;
        do_pop  = (qa.size() > 0) && rdy;
        do_push = v && (qa.size() < 2);
        @(posedge clk); #1;
        a_accepted = 1'b0;
        if (rs || fl) begin
            qa.delete();
        end else begin
            if (do_pop) void'(qa.pop_front());
            if (do_push) begin
                qa.push_back(d);
                a_accepted = 1'b1;
            end
        end
    endtask

    task automatic step4(input logic v, input logic [33:0] d, input logic rdy,
                         input logic fl, input logic rs);
        bit do_push, do_pop;
        b_valid_i = v; b_data_i = d; b_ready_i = rdy; b_flush = fl; b_rst = rs;
        do_pop  = (qb.size() > 0) && rdy;
        do_push = v && (qb.size() < 4);
        @(posedge clk); #1;
        b_accepted = 1'b0;
        if (rs || fl) begin
            qb.delete();
        end else begin
            if (do_pop) begin
                b_pop_log.push_back(qb.pop_front());
                b_popped++;
            end
            if (do_push) begin
                qb.push_back(d);
                b_accepted = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        step2(1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        step4(1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        step2(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step4(1'b0, '0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== {1'b0, 1'b0, 1'b1, 2'd0, 34'h0}) begin
            miscompares++;
            $display("FAIL reset2: got %h exp %h", obs2(), {1'b0, 1'b0, 1'b1, 2'd0, 34'h0});
        end
        vectors++;
        if (obs4() !== {1'b0, 1'b1, 3'd0, 34'h0}) begin
            miscompares++;
            $display("FAIL reset4: got %h exp %h", obs4(), {1'b0, 1'b1, 3'd0, 34'h0});
        end
    endtask

    task automatic test_single_beat();
        step2(1'b1, beat(32'hDEADBEEF, 2'd0), 1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hDEADBEEF, 2'd0)}) begin
            miscompares++;
            $display("FAIL single_visible: got %h exp %h", obs2(),
                     {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hDEADBEEF, 2'd0)});
        end
        step2(1'b0, '0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== exp2()) begin
            miscompares++;
            $display("FAIL single_drained: got %h exp %h", obs2(), exp2());
        end
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 1; i <= 8; i++) begin
            step2(1'b1, beat(32'(i), 2'd0), 1'b1, 1'b0, 1'b0);
            vectors++;
            if (obs2() !== {1'b0, 1'b1, 1'b1, 2'd1, beat(32'(i), 2'd0)}) begin
                miscompares++;
                $display("FAIL stream beat %0d: got %h exp %h", i, obs2(),
                         {1'b0, 1'b1, 1'b1, 2'd1, beat(32'(i), 2'd0)});
            end
        end
        step2(1'b0, '0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== exp2()) begin
            miscompares++;
            $display("FAIL stream_drain: got %h exp %h", obs2(), exp2());
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] items [3];
        logic [33:0] seen[$];
        int unsigned idx;
        items[0] = beat(32'h11, 2'd0);
        items[1] = beat(32'h22, 2'd2);
        items[2] = beat(32'h33, 2'd3);
        idx = 0;
        // Three offers with the consumer stalled: only A and B fit.
        for (int unsigned c = 0; c < 3; c++) begin
            step2(1'b1, items[idx], 1'b0, 1'b0, 1'b0);
            if (a_accepted) idx++;
        end
        vectors++;
        if (obs2() !== {1'b0, 1'b1, 1'b0, 2'd2, items[0]}) begin
            miscompares++;
            $display("FAIL bp_full: got %h exp %h", obs2(), {1'b0, 1'b1, 1'b0, 2'd2, items[0]});
        end
        vectors++;
        if (idx !== 2) begin
            miscompares++;
            $display("FAIL bp_accepted: got %0d exp %0d", idx, 2);
        end
        // Release: pop at full gives no same-cycle ready, so C waits one more cycle.
        for (int unsigned c = 0; c < 10 && seen.size() < 3; c++) begin
            if (a_valid_o) seen.push_back(a_data_o);
            step2(idx < 3, (idx < 3) ? items[idx] : 34'h0, 1'b1, 1'b0, 1'b0);
            if (a_accepted) idx++;
            vectors++;
            if (obs2() !== exp2()) begin
                miscompares++;
                $display("FAIL bp_release cyc %0d: got %h exp %h", c, obs2(), exp2());
            end
            if (c == 0) begin
                vectors++;
                if ({a_ready_o, a_count} !== {1'b1, 2'd1}) begin
                    miscompares++;
                    $display("FAIL bp_ready_rise: got %b exp %b", {a_ready_o, a_count}, 3'b101);
                end
            end
        end
        vectors++;
        if (seen.size() != 3 || seen[0] !== items[0] || seen[1] !== items[1]
            || seen[2] !== items[2]) begin
            miscompares++;
            $display("FAIL bp_order: got %0d beats, first %h exp A,B,C", seen.size(),
                     (seen.size() > 0) ? seen[0] : 34'h0);
        end
    endtask

    task automatic test_wrap();
        logic [33:0] items [10];
        int unsigned idx;
        bit          bad_order;
        for (int unsigned i = 0; i < 10; i++) items[i] = beat($urandom, 2'($urandom_range(0, 3)));
        idx = 0;
        b_popped = 0;
        b_pop_log.delete();
        for (int unsigned c = 0; c < 200 && b_popped < 10; c++) begin
            logic v;
            v = (idx < 10) && ($urandom_range(0, 3) != 0);
            step4(v, v ? items[idx] : 34'h0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (b_accepted) idx++;
            vectors++;
            if (obs4() !== exp4() || b_count > 3'd4) begin
                miscompares++;
                $display("FAIL wrap cyc %0d: got %h exp %h", c, obs4(), exp4());
            end
        end
        bad_order = (b_pop_log.size() != 10);
        for (int unsigned i = 0; i < b_pop_log.size() && i < 10; i++)
            if (b_pop_log[i] !== items[i]) bad_order = 1'b1;
        vectors++;
        if (bad_order) begin
            miscompares++;
            $display("FAIL wrap_order: got %0d beats exp 10 in order", b_pop_log.size());
        end
    endtask

    task automatic test_flush();
        step2(1'b1, beat(32'hA1, 2'd0), 1'b0, 1'b0, 1'b0);
        step2(1'b1, beat(32'hA2, 2'd0), 1'b0, 1'b0, 1'b0);
        step2(1'b1, beat(32'hF00D, 2'd3), 1'b1, 1'b1, 1'b0);
        vectors++;
        if (obs2() !== {1'b0, 1'b0, 1'b1, 2'd0, 34'h0}) begin
            miscompares++;
            $display("FAIL flush: got %h exp %h", obs2(), {1'b0, 1'b0, 1'b1, 2'd0, 34'h0});
        end
        step2(1'b1, beat(32'hB0, 2'd1), 1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hB0, 2'd1)}) begin
            miscompares++;
            $display("FAIL flush_next: got %h exp %h", obs2(),
                     {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hB0, 2'd1)});
        end
        step2(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_midstream_reset();
        step2(1'b1, beat(32'hC1, 2'd0), 1'b0, 1'b0, 1'b0);
        step2(1'b1, beat(32'hC2, 2'd0), 1'b0, 1'b0, 1'b0);
        step2(1'b1, beat(32'hC3, 2'd0), 1'b1, 1'b0, 1'b1);
        vectors++;
        if (obs2() !== {1'b0, 1'b0, 1'b1, 2'd0, 34'h0}) begin
            miscompares++;
            $display("FAIL midreset: got %h exp %h", obs2(), {1'b0, 1'b0, 1'b1, 2'd0, 34'h0});
        end
        step2(1'b1, beat(32'hE1, 2'd2), 1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs2() !== {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hE1, 2'd2)}) begin
            miscompares++;
            $display("FAIL midreset_first: got %h exp %h", obs2(),
                     {1'b0, 1'b1, 1'b1, 2'd1, beat(32'hE1, 2'd2)});
        end
        step2(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [33:0] pend;
        bit          have;
        have = 1'b0;
        pend = '0;
        for (int unsigned c = 0; c < 300; c++) begin
            logic fl, rs;
            if (!have && $urandom_range(0, 1) == 1) begin
                pend = beat($urandom, 2'($urandom_range(0, 3)));
                have = 1'b1;
            end
            fl = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step2(have, pend, 1'($urandom_range(0, 1)), fl, rs);
            if (a_accepted || fl || rs) have = 1'b0;
            vectors++;
            if (obs2() !== exp2()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h exp %h", c, obs2(), exp2());
            end
        end
    endtask

    initial begin
        a_rst = 1'b1; a_valid_i = 1'b0; a_ready_i = 1'b0; a_flush = 1'b0; a_data_i = '0;
        b_rst = 1'b1; b_valid_i = 1'b0; b_ready_i = 1'b0; b_flush = 1'b0; b_data_i = '0;
        a_accepted = 1'b0; b_accepted = 1'b0; b_popped = 0;
        @(posedge clk); #1;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_flush();
        test_midstream_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmi_resp_stage.md
Name: dmi_resp_stage

Overview:
- Response-direction buffer stage for the DMI link. Carries dm::dmi_resp_t from the debug-module side back towards the DTM.
- A small FIFO with registered valid/ready. Ready towards the producer depends only on internal state, never on the consumer's ready, so there is no combinational ready path through the stage.
- Sits on the response path, paired with the request-path stage, inside the DMI CDC/pipeline boundary.

Parameters:
- DEPTH, 2, number of buffered responses. Power of two, >= 2. DEPTH=2 gives full throughput with a registered ready.
- CntW, $clog2(DEPTH+1), width of count_o. Derived; not overridden.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous reset, active-high.
- dmi_resp_i  in  $bits(dm::dmi_resp_t) (34: data[31:0], resp[1:0])  response from DM.
- dmi_resp_valid_i  in  1  producer valid.
- dmi_resp_ready_o  out  1  stage can accept; equals !full.
- dmi_resp_o  out  34  head-of-queue response; 0 when empty.
- dmi_resp_valid_o  out  1  head valid; equals !empty.
- dmi_resp_ready_i  in  1  consumer ready.
- flush_i  in  1  synchronous discard of all buffered entries (dmireset / DTM hard reset).
- count_o  out  CntW  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst_i=1 at posedge): wr_ptr=rd_ptr=0, count=0, all storage=0.
  - Resulting outputs: dmi_resp_valid_o=0, dmi_resp_ready_o=1, dmi_resp_o=0, count_o=0.
- Storage and pointers:
  - DEPTH-entry register array; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter count is 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- Push: push = dmi_resp_valid_i && dmi_resp_ready_o.
  - Writes mem[wr_ptr] and increments wr_ptr.
- Pop: pop = dmi_resp_valid_o && dmi_resp_ready_i.
  - Increments rd_ptr.
- Outputs are combinational from registers only:
  - dmi_resp_o = mem[rd_ptr] when !empty, else 0.
  - dmi_resp_valid_o = !empty; dmi_resp_ready_o = !full.
- Latency: a response pushed at edge N is visible on dmi_resp_o/valid_o after edge N. Minimum 1 cycle; no fall-through when empty.
- Throughput: one response per cycle sustained with consumer ready=1 and DEPTH>=2.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Allowed at any non-full, non-empty occupancy.
  - When empty, only a push can occur; count becomes 1.
  - When full, ready_o=0, so only a pop occurs; count becomes DEPTH-1 and ready_o rises the next cycle.
  - A pop at full does not create same-cycle ready.
- Valid held while not accepted: the producer must keep data stable. The stage samples only on push and never re-samples.
- Consumer stall: head data and valid_o stay stable until pop.
- flush_i=1 at posedge:
  - Pointers and count return to 0; storage is not cleared; outputs read as empty (dmi_resp_o=0).
  - Any push or pop in the same cycle is ignored.
- Priority: rst_i > flush_i > push/pop.
- Reset mid-transfer discards all entries with no partial beat. The resp field is passed through unmodified; no code interpretation (0 success, 2 failed, 3 busy).
- Assertions for verification:
  - No push when full.
  - No pop when empty.
  - count == (wr_ptr - rd_ptr) mod DEPTH, or DEPTH when full.

Test Plan:
- Reset then idle -> valid_o=0, ready_o=1, resp_o=0, count_o=0.
- Single beat: push {data=32'hDEADBEEF, resp=0} with ready_i=1 -> valid_o=1 with that data on the next cycle, popped that cycle, count_o returns 0.
- Back-to-back stream: 8 beats data=1..8, ready_i=1 throughout -> output 1..8 in order on consecutive cycles, ready_o never drops, count_o steady at 1.
- Backpressure (DEPTH=2):
  - Push A=32'h11, B=32'h22, C=32'h33 with ready_i=0 -> A and B accepted, ready_o=0, count_o=2, C held by producer.
  - Then ready_i=1 -> A out, ready_o=1 next cycle, C accepted, order A,B,C.
- Wrap-around with DEPTH=4: 10 pushes and 10 pops interleaved with random ready_i -> in-order data across pointer wrap, count_o always within 0..4.
- Flush with 2 entries held and a simultaneous push {resp=3} -> next cycle count_o=0, valid_o=0, resp_o=0, pushed beat dropped.
- Mid-stream reset: rst_i=1 while full -> next cycle empty and ready_o=1; the first post-reset beat appears first.
